instruction_fetch_controller: RTL and testbench
===============================================

Name: instruction_fetch_controller

Overview:
Sequences the byte-addressed, little-endian instruction memory.
- Holds the program counter and drives the memory read address.
- Waits a programmable number of cycles for the memory's combinational delay to settle, then captures the 32-bit word.
- Presents the word to decode over a valid/ready handshake, and supports PC redirect (branch) and address-fault detection.
- Sits between the instruction memory and the decode stage.

Parameters:
- RESET_PC, 64'h0, PC value loaded at reset.
- WAIT_CYCLES, 2, settle cycles after the address is driven before capture (0..15).
- MEM_BYTES, 128, instruction memory size in bytes; legal fetch addresses are 0..MEM_BYTES-4.

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- fetch_en  input  1  permits new fetches to start.
- mem_address  output  64  read address to the instruction memory; equals the internal PC.
- mem_instruction  input  32  assembled word returned by the memory.
- inst_out  output  32  captured instruction.
- inst_pc  output  64  address inst_out was fetched from.
- inst_valid  output  1  inst_out/inst_pc valid.
- inst_ready  input  1  decode accepts the instruction.
- redirect_valid  input  1  load a new PC (single-cycle pulse).
- redirect_pc  input  64  target PC for a redirect.
- fault  output  1  sticky misaligned/out-of-range fetch flag.
- fetch_count  output  32  number of completed handshakes; wraps at 2^32.

Behaviour:
Reset (asynchronous, rst_n=0):
- state=IDLE; pc=RESET_PC; wait counter=WAIT_CYCLES.
- inst_out=0, inst_pc=0, inst_valid=0, fault=0, fetch_count=0.
- mem_address is always pc.
- Reset asserted mid-fetch aborts the fetch immediately with no capture.

States: IDLE, WAIT, VALID, FAULT.

Address check (applied wherever "enter WAIT" appears below):
- Fails if pc[1:0]!=0 or pc>MEM_BYTES-4 (unsigned 64-bit compare).
- Failure: go to FAULT instead of WAIT.

IDLE:
- If fetch_en=1, reload counter=WAIT_CYCLES and enter WAIT.

WAIT:
- pc is held.
- If counter!=0, decrement.
- If counter==0:
  - inst_out<=mem_instruction, inst_pc<=pc, inst_valid<=1.
  - pc<=pc+4 (64-bit, wrapping).
  - Go to VALID.
- Latency: inst_valid rises WAIT_CYCLES+1 cycles after entering WAIT.
- fetch_en deasserting in WAIT does not abort the fetch in progress.

VALID:
- inst_valid=1; inst_out and inst_pc stable until the handshake.
- Handshake = inst_valid & inst_ready:
  - fetch_count+1; inst_valid<=0.
  - Next state: WAIT (counter reloaded, address check) if fetch_en=1, else IDLE.
- No back-to-back valids: minimum gap is WAIT_CYCLES+1 cycles.

Redirect (any state except FAULT; highest priority):
- pc<=redirect_pc; counter reloaded; inst_valid<=0 (held instruction flushed).
- Next state: WAIT (with address check) if fetch_en=1, else IDLE.
- If the redirect coincides with a VALID handshake, the handshake still counts (fetch_count increments) and the redirect then applies.
- A redirect during WAIT discards the in-flight fetch; nothing is captured that cycle.

FAULT:
- fault=1, inst_valid=0, pc frozen.
- Redirect and fetch_en are ignored; exit only via reset.

Width rules:
- pc+4 and fetch_count wrap silently.
- mem_instruction is sampled only in the WAIT capture cycle.

Test Plan:
1. Memory preloaded with words 0x8B1F03E5, 0xF84000A4, 0x8B040086, 0xF80010A6; WAIT_CYCLES=2; release reset, fetch_en=1, inst_ready=1 -> inst_valid first high 3 cycles after WAIT entry with inst_out=0x8B1F03E5, inst_pc=0. Then inst_pc steps 4, 8, 12 with inst_out 0xF84000A4, 0x8B040086, 0xF80010A6; fetch_count=4.
2. Backpressure: inst_ready=0 for 5 cycles while valid -> inst_out and inst_pc held unchanged, mem_address=4, fetch_count unchanged; inst_ready=1 -> one handshake, fetch_count+1.
3. Redirect during WAIT, redirect_pc=12 -> no capture of the address-4 word; next inst_valid carries inst_pc=12, inst_out=0xF80010A6.
4. Redirect together with a VALID handshake -> fetch_count increments, next inst_pc equals the redirect target. redirect_pc=0x6 -> fault=1 and inst_valid=0 forever. redirect_pc=128 (MEM_BYTES) -> fault=1.
5. Fetch at pc=124 succeeds. Sequential advance to 128 -> FAULT on the address check, fault=1. Further redirects are ignored; rst_n pulse clears fault and restores pc=0.
6. Assert rst_n=0 asynchronously mid-WAIT (between clock edges) -> outputs return to reset values immediately without a clock edge; fetch restarts cleanly at RESET_PC after release.

Source files
------------

// File: rtl/instruction_fetch_controller.sv
// Purpose: holds the PC, drives instruction memory, captures the word after a settle delay and hands it to decode.
// Latency: inst_valid rises WAIT_CYCLES+1 cycles after a fetch launches; no back-to-back valids.
// Backpressure: inst_valid/inst_out/inst_pc hold until inst_ready; redirects flush the held word.
module instruction_fetch_controller #(
    parameter logic [63:0] RESET_PC    = 64'h0,
    parameter int          WAIT_CYCLES = 2,
    parameter int          MEM_BYTES   = 128
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        fetch_en,
    output logic [63:0] mem_address,
    input  logic [31:0] mem_instruction,
    output logic [31:0] inst_out,
    output logic [63:0] inst_pc,
    output logic        inst_valid,
    input  logic        inst_ready,
    input  logic        redirect_valid,
    input  logic [63:0] redirect_pc,
    output logic        fault,
    output logic [31:0] fetch_count
);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_VALID, S_FAULT} state_t;

    localparam logic [3:0]  WAIT_INIT = 4'(WAIT_CYCLES);
    localparam logic [63:0] PC_MAX    = 64'(MEM_BYTES - 4);

    state_t      state_q, state_d;
    logic [63:0] pc_q, pc_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [31:0] inst_out_q, inst_out_d;
    logic [63:0] inst_pc_q, inst_pc_d;
    logic        inst_valid_q, inst_valid_d;
    logic        fault_q, fault_d;
    logic [31:0] fetch_count_q, fetch_count_d;
    logic        handshake;
    logic        launch;
    logic [63:0] launch_pc;

    function automatic logic addr_ok(input logic [63:0] a);
        return (a[1:0] == 2'b00) && (a <= PC_MAX);
    endfunction

    assign handshake = inst_valid_q && inst_ready;

    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        cnt_d         = cnt_q;
        inst_out_d    = inst_out_q;
        inst_pc_d     = inst_pc_q;
        inst_valid_d  = inst_valid_q;
        fault_d       = fault_q;
        fetch_count_d = fetch_count_q;
        launch        = 1'b0;
        launch_pc     = pc_q;

        if (handshake) begin
            fetch_count_d = fetch_count_q + 32'd1;
        end

        // Redirect outranks everything except the sticky fault state.
        if (state_q != S_FAULT && redirect_valid) begin
            pc_d         = redirect_pc;
            launch_pc    = redirect_pc;
            cnt_d        = WAIT_INIT;
            inst_valid_d = 1'b0;
            state_d      = S_IDLE;
            launch       = fetch_en;
        end else begin
            unique case (state_q)
                S_IDLE: launch = fetch_en;
                S_WAIT: begin
                    if (cnt_q != 4'd0) begin
                        cnt_d = cnt_q - 4'd1;
                    end else begin
                        inst_out_d   = mem_instruction;
                        inst_pc_d    = pc_q;
                        inst_valid_d = 1'b1;
                        pc_d         = pc_q + 64'd4;
                        state_d      = S_VALID;
                    end
                end
                S_VALID: begin
                    if (handshake) begin
                        inst_valid_d = 1'b0;
                        state_d      = S_IDLE;
                        launch       = fetch_en;
                    end
                end
                S_FAULT: begin
                    inst_valid_d = 1'b0;
                    fault_d      = 1'b1;
                end
            endcase
        end

        if (launch) begin
            cnt_d = WAIT_INIT;
            if (addr_ok(launch_pc)) begin
                state_d = S_WAIT;
            end else begin
                state_d      = S_FAULT;
                fault_d      = 1'b1;
                inst_valid_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= S_IDLE;
            pc_q          <= RESET_PC;
            cnt_q         <= WAIT_INIT;
            inst_out_q    <= 32'd0;
            inst_pc_q     <= 64'd0;
            inst_valid_q  <= 1'b0;
            fault_q       <= 1'b0;
            fetch_count_q <= 32'd0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            cnt_q         <= cnt_d;
            inst_out_q    <= inst_out_d;
            inst_pc_q     <= inst_pc_d;
            inst_valid_q  <= inst_valid_d;
            fault_q       <= fault_d;
            fetch_count_q <= fetch_count_d;
        end
    end

    assign mem_address = pc_q;
    assign inst_out    = inst_out_q;
    assign inst_pc     = inst_pc_q;
    assign inst_valid  = inst_valid_q;
    assign fault       = fault_q;
    assign fetch_count = fetch_count_q;

endmodule

// File: tb/tb_instruction_fetch_controller.sv
// Bench for instruction_fetch_controller: byte-array memory, directed scenarios, then a randomized
// run scored against a transaction-level model (expected PC stream, latency, handshake count).
module tb_instruction_fetch_controller;

    localparam int WAIT_CYCLES = 2;
    localparam int MEM_BYTES   = 128;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        fetch_en = 1'b0;
    logic [63:0] mem_address;
    logic [31:0] mem_instruction;
    logic [31:0] inst_out;
    logic [63:0] inst_pc;
    logic        inst_valid;
    logic        inst_ready = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [63:0] redirect_pc = 64'd0;
    logic        fault;
    logic [31:0] fetch_count;

    int tests = 0;
    int fails = 0;
    logic [7:0] mem_b [MEM_BYTES];

    instruction_fetch_controller #(
        .RESET_PC(64'h0), .WAIT_CYCLES(WAIT_CYCLES), .MEM_BYTES(MEM_BYTES)
    ) dut (
        .clk(clk), .rst_n(rst_n), .fetch_en(fetch_en), .mem_address(mem_address),
        .mem_instruction(mem_instruction), .inst_out(inst_out), .inst_pc(inst_pc),
        .inst_valid(inst_valid), .inst_ready(inst_ready), .redirect_valid(redirect_valid),
        .redirect_pc(redirect_pc), .fault(fault), .fetch_count(fetch_count)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [63:0] a);
        int i;
        if (a > 64'(MEM_BYTES - 4)) return 32'hDEADBEEF;
        i = int'(a[6:0]);
        return {mem_b[i+3], mem_b[i+2], mem_b[i+1], mem_b[i]};
    endfunction

    always_comb mem_instruction = mem_word(mem_address);

    task automatic load_word(input int a, input logic [31:0] w);
        mem_b[a]   = w[7:0];
        mem_b[a+1] = w[15:8];
        mem_b[a+2] = w[23:16];
        mem_b[a+3] = w[31:24];
    endtask

    task automatic do_reset();
        rst_n = 1'b0; fetch_en = 1'b0; inst_ready = 1'b0;
        redirect_valid = 1'b0; redirect_pc = 64'd0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic wait_valid(output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!inst_valid && n < 50);
        if (!inst_valid) begin
            tests++; fails++;
            $display("FAIL wait_valid: timeout after %0d cycles, inst_valid=%b required 1", n, inst_valid);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #3;
        tests++; if (inst_valid !== 1'b0) begin fails++; $display("FAIL reset_valid: got %b want 0", inst_valid); end
        tests++; if (inst_out !== 32'd0) begin fails++; $display("FAIL reset_out: got %h want 0", inst_out); end
        tests++; if (inst_pc !== 64'd0) begin fails++; $display("FAIL reset_pc: got %h want 0", inst_pc); end
        tests++; if (fault !== 1'b0) begin fails++; $display("FAIL reset_fault: got %b want 0", fault); end
        tests++; if (fetch_count !== 32'd0) begin fails++; $display("FAIL reset_count: got %0d want 0", fetch_count); end
        tests++; if (mem_address !== 64'd0) begin fails++; $display("FAIL reset_addr: got %h want 0", mem_address); end
    endtask

    task automatic test_sequential();
        logic [31:0] words [4];
        int n;
        words[0] = 32'h8B1F03E5; words[1] = 32'hF84000A4; words[2] = 32'h8B040086; words[3] = 32'hF80010A6;
        do_reset();
        fetch_en = 1'b1; inst_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            wait_valid(n);
            // one IDLE cycle before the first launch, then WAIT_CYCLES+1 per fetch
            tests++; if (n !== WAIT_CYCLES + 2) begin fails++; $display("FAIL seq_latency[%0d]: got %0d want %0d", k, n, WAIT_CYCLES + 2); end
            tests++; if (inst_pc !== 64'(4 * k)) begin fails++; $display("FAIL seq_pc[%0d]: got %h want %h", k, inst_pc, 4 * k); end
            tests++; if (inst_out !== words[k]) begin fails++; $display("FAIL seq_out[%0d]: got %h want %h", k, inst_out, words[k]); end
        end
        @(negedge clk);
        tests++; if (fetch_count !== 32'd4) begin fails++; $display("FAIL seq_count: got %0d want 4", fetch_count); end
        tests++; if (inst_valid !== 1'b0) begin fails++; $display("FAIL seq_drop: got %b want 0", inst_valid); end
    endtask

    task automatic test_backpressure();
        int n;
        do_reset();
        fetch_en = 1'b1; inst_ready = 1'b0;
        wait_valid(n);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            tests++; if (inst_valid !== 1'b1 || inst_pc !== 64'd0 || inst_out !== 32'h8B1F03E5)
                begin fails++; $display("FAIL bp_hold[%0d]: got v=%b pc=%h out=%h want 1/0/8b1f03e5", k, inst_valid, inst_pc, inst_out); end
            tests++; if (mem_address !== 64'd4) begin fails++; $display("FAIL bp_addr[%0d]: got %h want 4", k, mem_address); end
            tests++; if (fetch_count !== 32'd0) begin fails++; $display("FAIL bp_count[%0d]: got %0d want 0", k, fetch_count); end
        end
        inst_ready = 1'b1;
        @(negedge clk);
        tests++; if (fetch_count !== 32'd1) begin fails++; $display("FAIL bp_release: got %0d want 1", fetch_count); end
        tests++; if (inst_valid !== 1'b0) begin fails++; $display("FAIL bp_drop: got %b want 0", inst_valid); end
    endtask

    task automatic test_redirect_wait();
        int n;
        do_reset();
        fetch_en = 1'b1; inst_ready = 1'b1;
        wait_valid(n);
        @(negedge clk);
        tests++; if (mem_address !== 64'd4) begin fails++; $display("FAIL rw_addr: got %h want 4", mem_address); end
        redirect_valid = 1'b1; redirect_pc = 64'd12;
        @(negedge clk);
        redirect_valid = 1'b0;
        tests++; if (inst_valid !== 1'b0) begin fails++; $display("FAIL rw_flush: got %b want 0", inst_valid); end
        wait_valid(n);
        tests++; if (n !== WAIT_CYCLES + 1) begin fails++; $display("FAIL rw_latency: got %0d want %0d", n, WAIT_CYCLES + 1); end
        tests++; if (inst_pc !== 64'd12) begin fails++; $display("FAIL rw_pc: got %h want c", inst_pc); end
        tests++; if (inst_out !== 32'hF80010A6) begin fails++; $display("FAIL rw_out: got %h want f80010a6", inst_out); end
        tests++; if (fetch_count !== 32'd1) begin fails++; $display("FAIL rw_count: got %0d want 1", fetch_count); end
    endtask

    task automatic test_redirect_handshake();
        int n;
        do_reset();
        fetch_en = 1'b1; inst_ready = 1'b1;
        wait_valid(n);
        redirect_valid = 1'b1; redirect_pc = 64'd8;
        @(negedge clk);
        redirect_valid = 1'b0;
        tests++; if (fetch_count !== 32'd1) begin fails++; $display("FAIL rh_count: got %0d want 1", fetch_count); end
        wait_valid(n);
        tests++; if (inst_pc !== 64'd8 || inst_out !== 32'h8B040086)
            begin fails++; $display("FAIL rh_target: got pc=%h out=%h want 8/8b040086", inst_pc, inst_out); end
        redirect_valid = 1'b1; redirect_pc = 64'd6;
        @(negedge clk);
        redirect_valid = 1'b0;
        tests++; if (fault !== 1'b1 || inst_valid !== 1'b0) begin fails++; $display("FAIL rh_misalign: got fault=%b v=%b want 1/0", fault, inst_valid); end
        tests++; if (fetch_count !== 32'd2) begin fails++; $display("FAIL rh_count2: got %0d want 2", fetch_count); end
        for (int k = 0; k < 10; k++) begin
            redirect_valid = 1'($urandom_range(0, 1)); redirect_pc = 64'd0; fetch_en = 1'($urandom_range(0, 1));
            @(negedge clk);
            tests++; if (fault !== 1'b1 || inst_valid !== 1'b0 || mem_address !== 64'd6)
                begin fails++; $display("FAIL rh_sticky[%0d]: got fault=%b v=%b addr=%h want 1/0/6", k, fault, inst_valid, mem_address); end
        end
        do_reset();
        fetch_en = 1'b1;
        @(negedge clk);
        redirect_valid = 1'b1; redirect_pc = 64'd128;
        @(negedge clk);
        redirect_valid = 1'b0;
        tests++; if (fault !== 1'b1 || mem_address !== 64'd128 || inst_valid !== 1'b0)
            begin fails++; $display("FAIL rh_range: got fault=%b addr=%h v=%b want 1/80/0", fault, mem_address, inst_valid); end
    endtask

    task automatic test_end_of_memory();
        int n;
        do_reset();
        load_word(124, 32'h1234ABCD);
        fetch_en = 1'b1; inst_ready = 1'b0;
        redirect_valid = 1'b1; redirect_pc = 64'd124;
        @(negedge clk);
        redirect_valid = 1'b0;
        wait_valid(n);
        tests++; if (inst_pc !== 64'd124 || inst_out !== 32'h1234ABCD || fault !== 1'b0)
            begin fails++; $display("FAIL eom_fetch: got pc=%h out=%h fault=%b want 7c/1234abcd/0", inst_pc, inst_out, fault); end
        inst_ready = 1'b1;
        @(negedge clk);
        tests++; if (fault !== 1'b1 || mem_address !== 64'd128 || fetch_count !== 32'd1)
            begin fails++; $display("FAIL eom_fault: got fault=%b addr=%h cnt=%0d want 1/80/1", fault, mem_address, fetch_count); end
        redirect_valid = 1'b1; redirect_pc = 64'd0;
        @(negedge clk);
        redirect_valid = 1'b0;
        tests++; if (fault !== 1'b1 || mem_address !== 64'd128)
            begin fails++; $display("FAIL eom_ignore: got fault=%b addr=%h want 1/80", fault, mem_address); end
        do_reset();
        #1;
        tests++; if (fault !== 1'b0 || mem_address !== 64'd0)
            begin fails++; $display("FAIL eom_clear: got fault=%b addr=%h want 0/0", fault, mem_address); end
    endtask

    task automatic test_async_reset();
        int n;
        do_reset();
        fetch_en = 1'b1; inst_ready = 1'b1;
        wait_valid(n);
        @(negedge clk);
        inst_ready = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        tests++; if (mem_address !== 64'd0 || fetch_count !== 32'd0 || inst_out !== 32'd0 || inst_valid !== 1'b0)
            begin fails++; $display("FAIL async_reset: got addr=%h cnt=%0d out=%h v=%b want 0/0/0/0", mem_address, fetch_count, inst_out, inst_valid); end
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1; inst_ready = 1'b1;
        wait_valid(n);
        tests++; if (n !== WAIT_CYCLES + 2 || inst_pc !== 64'd0 || inst_out !== 32'h8B1F03E5)
            begin fails++; $display("FAIL async_restart: got n=%0d pc=%h out=%h want %0d/0/8b1f03e5", n, inst_pc, inst_out, WAIT_CYCLES + 2); end
    endtask

    // Model tracks only transactions: which PC the next delivered word must come from,
    // how many handshakes happened, and how long since the last launch event.
    task automatic test_random();
        logic [63:0] exp_pc, held_pc;
        logic [31:0] held_out;
        logic [31:0] m_count;
        logic        pending, lat_known, rdy, redir, hs;
        logic [63:0] tgt;
        int          low_cnt;
        for (int i = 0; i < MEM_BYTES; i++) mem_b[i] = 8'($urandom);
        do_reset();
        fetch_en = 1'b1;
        exp_pc = 64'd0; pending = 1'b1; lat_known = 1'b0; low_cnt = 0; m_count = 32'd0;
        held_pc = 64'd0; held_out = 32'd0;
        for (int cyc = 0; cyc < 600; cyc++) begin
            @(negedge clk);
            tests++; if (fetch_count !== m_count) begin fails++; $display("FAIL rnd_count[%0d]: got %0d want %0d", cyc, fetch_count, m_count); end
            if (inst_valid) begin
                if (pending) begin
                    tests++; if (inst_pc !== exp_pc) begin fails++; $display("FAIL rnd_pc[%0d]: got %h want %h", cyc, inst_pc, exp_pc); end
                    tests++; if (inst_out !== mem_word(exp_pc)) begin fails++; $display("FAIL rnd_out[%0d]: got %h want %h", cyc, inst_out, mem_word(exp_pc)); end
                    if (lat_known) begin
                        tests++; if (low_cnt !== WAIT_CYCLES + 1) begin fails++; $display("FAIL rnd_latency[%0d]: got %0d want %0d", cyc, low_cnt, WAIT_CYCLES + 1); end
                    end
                    pending = 1'b0; held_pc = inst_pc; held_out = inst_out;
                end else begin
                    tests++; if (inst_pc !== held_pc || inst_out !== held_out)
                        begin fails++; $display("FAIL rnd_stable[%0d]: got %h/%h want %h/%h", cyc, inst_pc, inst_out, held_pc, held_out); end
                end
                tests++; if (mem_address !== inst_pc + 64'd4) begin fails++; $display("FAIL rnd_addr[%0d]: got %h want %h", cyc, mem_address, inst_pc + 64'd4); end
            end else begin
                low_cnt++;
            end
            rdy   = 1'($urandom_range(0, 1));
            redir = ($urandom_range(0, 7) == 0) || (inst_valid && inst_pc == 64'(MEM_BYTES - 4));
            tgt   = 64'($urandom_range(0, MEM_BYTES / 4 - 1)) * 64'd4;
            hs    = inst_valid && rdy;
            if (hs) m_count = m_count + 32'd1;
            if (redir) begin
                exp_pc = tgt; pending = 1'b1; low_cnt = 0; lat_known = 1'b1;
            end else if (hs) begin
                exp_pc = inst_pc + 64'd4; pending = 1'b1; low_cnt = 0; lat_known = 1'b1;
            end
            inst_ready = rdy; redirect_valid = redir; redirect_pc = tgt;
        end
        redirect_valid = 1'b0;
        tests++; if (fault !== 1'b0) begin fails++; $display("FAIL rnd_fault: got %b want 0", fault); end
    endtask

    initial begin
        for (int i = 0; i < MEM_BYTES; i++) mem_b[i] = 8'(i * 7 + 3);
        load_word(0, 32'h8B1F03E5);
        load_word(4, 32'hF84000A4);
        load_word(8, 32'h8B040086);
        load_word(12, 32'hF80010A6);
        test_reset();
        test_sequential();
        test_backpressure();
        test_redirect_wait();
        test_redirect_handshake();
        test_end_of_memory();
        test_async_reset();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, tests=%0d failed=%0d", tests, fails);
        $fatal(1, "watchdog");
    end

endmodule
